// File: rtl/avr_spi_slave.sv
// SPI mode-0 slave that moves bytes between the AVR and the fabric.
// All pins are synchronised and traffic is gated by the CCLK detector's ready.
module avr_spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ready,
  input  logic       ss,
  input  logic       mosi,
  input  logic       sck,
  output logic       miso,
  output logic       miso_en,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       done
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sck_q, ss_q, mosi_q;
  logic                   sck_prev;
  logic                   sck_sync, ss_sync, mosi_sync;
  logic                   active, sck_rise, sck_fall;
  logic [2:0]             bit_cnt;
  logic [7:0]             shift;
  logic                   load_din, shift_en, byte_end, miso_shift;

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_q    <= '0;
      ss_q     <= '0;
      mosi_q   <= '0;
      sck_prev <= 1'b0;
    end else begin
      sck_q    <= {sck_q[SYNC_STAGES-2:0], sck};
      ss_q     <= {ss_q[SYNC_STAGES-2:0], ss};
      mosi_q   <= {mosi_q[SYNC_STAGES-2:0], mosi};
      sck_prev <= sck_sync;
    end
  end

  assign sck_sync  = sck_q[SYNC_STAGES-1];
  assign ss_sync   = ss_q[SYNC_STAGES-1];
  assign mosi_sync = mosi_q[SYNC_STAGES-1];
  assign active    = ready & ~ss_sync;
  assign sck_rise  = sck_sync & ~sck_prev;
  assign sck_fall  = ~sck_sync & sck_prev;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (active)  state_next = ACTIVE;
      ACTIVE:  if (!active) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A deselect in the same cycle as an edge suppresses the edge entirely.
  always_comb begin
    load_din   = 1'b0;
    shift_en   = 1'b0;
    byte_end   = 1'b0;
    miso_shift = 1'b0;
    case (state)
      IDLE: load_din = 1'b1;
      ACTIVE: begin
        if (active) begin
          shift_en   = sck_rise;
          byte_end   = sck_rise && (bit_cnt == 3'd7);
          miso_shift = sck_fall;
        end
      end
      default: load_din = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      miso    <= 1'b0;
      miso_en <= 1'b0;
      dout    <= 8'h00;
      done    <= 1'b0;
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
    end else begin
      miso_en <= active;
      done    <= byte_end;
      if (load_din) begin
        bit_cnt <= 3'd0;
        shift   <= din;
        miso    <= din[7];
      end else if (!active) begin
        bit_cnt <= 3'd0;
      end else begin
        if (shift_en) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (byte_end) begin
            dout  <= {shift[6:0], mosi_sync};
            shift <= din;
          end else begin
            shift <= {shift[6:0], mosi_sync};
          end
        end
        if (miso_shift) miso <= shift[7];
      end
    end
  end

endmodule

// File: tb/tb_avr_spi_slave.sv
// Scoreboard bench for avr_spi_slave: a bit-banged mode-0 master at clk/8,
// expected bytes queued on issue and checked by a monitor on each done pulse.
module tb_avr_spi_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ready = 1'b0;
  logic       ss = 1'b1;
  logic       mosi = 1'b0;
  logic       sck = 1'b0;
  logic       miso, miso_en, done;
  logic [7:0] din = 8'h00;
  logic [7:0] dout;

  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_q[$];
  logic       done_prev = 1'b0;
  logic [7:0] rx;
  logic       en_seen;

  avr_spi_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .ready(ready), .ss(ss), .mosi(mosi), .sck(sck),
    .miso(miso), .miso_en(miso_en), .din(din), .dout(dout), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Master shifts nbits of tx MSB first, sampling miso on each rising sck.
  task automatic applyStimulus(input logic [7:0] tx, input int nbits,
                               output logic [7:0] rx_byte, output logic en_any);
    rx_byte = 8'h00;
    en_any  = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      waitCycles(4);
      sck = 1'b1;
      rx_byte = {rx_byte[6:0], miso};
      en_any  = en_any | miso_en;
      waitCycles(4);
      en_any  = en_any | miso_en;
      sck = 1'b0;
    end
  endtask

  task automatic selectSlave();
    ss = 1'b1;
    waitCycles(8);
    ss = 1'b0;
    waitCycles(8);
  endtask

  always @(negedge clk) begin
    if (done) begin
      checkOutput("done_width", int'(done_prev), 0);
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_done", int'(dout), -1);
      end else begin
        checkOutput("dout", int'(dout), int'(exp_q.pop_front()));
      end
    end
    done_prev = done;
  end

  initial begin
    @(negedge clk);
    rst = 1'b1;
    waitCycles(2);
    checkOutput("rst_miso", int'(miso), 0);
    checkOutput("rst_miso_en", int'(miso_en), 0);
    checkOutput("rst_dout", int'(dout), 0);
    checkOutput("rst_done", int'(done), 0);
    rst = 1'b0;
    waitCycles(4);

    // Not configured yet: a full byte must be ignored.
    ready = 1'b0;
    ss = 1'b0;
    waitCycles(8);
    applyStimulus(8'h5A, 8, rx, en_seen);
    waitCycles(8);
    checkOutput("t3_miso_en_seen", int'(en_seen), 0);
    checkOutput("t3_dout", int'(dout), 8'h00);
    checkOutput("t3_pending", exp_q.size(), 0);

    ready = 1'b1;
    din = 8'hA5;
    selectSlave();
    checkOutput("t1_miso_en", int'(miso_en), 1);
    exp_q.push_back(8'h3C);
    applyStimulus(8'h3C, 8, rx, en_seen);
    waitCycles(8);
    checkOutput("t1_rx", int'(rx), 8'hA5);
    checkOutput("t1_pending", exp_q.size(), 0);

    din = 8'h55;
    selectSlave();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'hFE);
    fork
      applyStimulus(8'h01, 8, rx, en_seen);
      begin
        waitCycles(20);
        din = 8'hAA;
      end
    join
    checkOutput("t2_rx0", int'(rx), 8'h55);
    applyStimulus(8'hFE, 8, rx, en_seen);
    checkOutput("t2_rx1", int'(rx), 8'hAA);
    waitCycles(8);
    checkOutput("t2_pending", exp_q.size(), 0);

    din = 8'h00;
    selectSlave();
    applyStimulus(8'hFF, 5, rx, en_seen);
    selectSlave();
    exp_q.push_back(8'h81);
    applyStimulus(8'h81, 8, rx, en_seen);
    waitCycles(8);
    checkOutput("t4_pending", exp_q.size(), 0);
    checkOutput("t4_dout", int'(dout), 8'h81);

    selectSlave();
    applyStimulus(8'hF0, 3, rx, en_seen);
    ready = 1'b0;
    checkOutput("t5_miso_en_before", int'(miso_en), 1);
    waitCycles(1);
    checkOutput("t5_miso_en_after", int'(miso_en), 0);
    applyStimulus(8'hF0, 5, rx, en_seen);
    waitCycles(4);
    ready = 1'b1;
    din = 8'h96;
    selectSlave();
    exp_q.push_back(8'h7E);
    applyStimulus(8'h7E, 8, rx, en_seen);
    waitCycles(8);
    checkOutput("t5_rx", int'(rx), 8'h96);
    checkOutput("t5_pending", exp_q.size(), 0);

    selectSlave();
    applyStimulus(8'hFF, 4, rx, en_seen);
    rst = 1'b1;
    waitCycles(1);
    checkOutput("t6_miso", int'(miso), 0);
    checkOutput("t6_miso_en", int'(miso_en), 0);
    checkOutput("t6_dout", int'(dout), 0);
    checkOutput("t6_done", int'(done), 0);
    rst = 1'b0;
    din = 8'h3C;
    selectSlave();
    exp_q.push_back(8'hC3);
    applyStimulus(8'hC3, 8, rx, en_seen);
    waitCycles(8);
    checkOutput("t6_rx", int'(rx), 8'h3C);
    checkOutput("t6_pending", exp_q.size(), 0);
    checkOutput("t6_dout_final", int'(dout), 8'hC3);

    ss = 1'b1;
    waitCycles(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/avr_spi_slave.md
Name: avr_spi_slave

Overview:
- SPI mode-0 slave that carries byte traffic between the on-board AVR and the FPGA fabric.
- Sits directly downstream of the CCLK detector and consumes its ready output. SPI traffic is accepted only while ready is high, so the slave never responds while the AVR is still configuring the FPGA.
- Synchronises the external SPI pins, shifts bytes MSB-first, and exposes a byte-parallel interface to the fabric: a received byte with a one-cycle done strobe, and a transmit byte that is loaded at each byte boundary.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each pin synchroniser (sck, ss, mosi). Legal values ≥2.

Ports:
- clk  input  1  system clock; must run at ≥4x the sck frequency.
- rst  input  1  synchronous, active-high reset.
- ready  input  1  from the CCLK detector; high means the AVR is configured and SPI traffic is allowed.
- ss  input  1  SPI slave select from the AVR, active low, asynchronous to clk.
- mosi  input  1  SPI data from the AVR, asynchronous to clk.
- sck  input  1  SPI clock from the AVR, asynchronous to clk.
- miso  output  1  SPI data to the AVR; registered.
- miso_en  output  1  tri-state enable for the miso pad.
- din  input  8  byte to transmit; sampled at each load point.
- dout  output  8  last byte received; held until the next byte completes.
- done  output  1  one-cycle pulse when dout updates.

Behaviour:
Reset:
- On rst, all of the following clear to 0: miso, miso_en, dout, done, bit counter, shift register, state, and synchroniser and edge-history flops.
- Reset mid-byte discards the partial byte; done does not assert.

Synchronisation and edges:
- sck, ss and mosi each pass through SYNC_STAGES flops.
- A previous-value flop on synced sck provides rise/fall detection.
- A pin edge is acted on SYNC_STAGES+1 clk cycles after it occurs.

Gating:
- The effective select is active = ready AND NOT ss_sync.
- miso_en = registered active, so it updates one cycle after active changes.
- The block ignores all activity while active is low, including sck edges.

State machine:
- IDLE
  - Bit counter is held at 0.
  - Shift register is loaded continuously with din.
  - miso is continuously driven with din[7].
  - Transitions to ACTIVE on the first cycle in which active is 1.
- ACTIVE, sck rising edge:
  - shift <= {shift[6:0], mosi_sync}.
  - Bit counter increments mod 8.
  - When the counter was 7:
    - dout <= {shift[6:0], mosi_sync}.
    - done = 1 for exactly one cycle.
    - Shift register reloads with din, not the shifted value.
    - Counter wraps to 0.
- ACTIVE, sck falling edge: miso <= shift[7].
- ACTIVE to IDLE occurs on any cycle in which active is 0, whether because ss went high or ready dropped.
  - Any partial byte is discarded and done does not assert.
  - dout keeps its previous value.

Boundary conditions:
- ready falls mid-byte: abort as for ss high; miso_en drops one cycle later.
- ss rising and an sck rising edge detected in the same cycle: ss wins, so no shift and no done.
- Back-to-back bytes with ss held low: there are no idle cycles between bytes. The 8th rising edge reloads din, so miso presents the new din[7] before the next byte's first rising edge.
- din is sampled only at load points: in IDLE and at the 8th-bit rising edge. Changes to din at other times do not affect the byte in flight.
- done never asserts while active is 0.

Latency:
- done asserts SYNC_STAGES+1 cycles after the 8th physical sck rise.
- miso changes SYNC_STAGES+1 cycles after the physical sck fall.

Test Plan:
1. Reset, then ready=1, ss=0, din=8'hA5, and the master clocks 8'h3C at clk/8 -> dout=8'h3C, done high for exactly 1 cycle; master captures 8'hA5 on miso.
2. ss held low for two bytes, master sends 8'h01 then 8'hFE; din=8'h55 for byte 1, changed to 8'hAA before the first byte completes -> two done pulses with dout 8'h01 then 8'hFE; master receives 8'h55 then 8'hAA.
3. ready=0, ss=0, master clocks 8 bits -> no done, dout stays 8'h00, miso_en=0 throughout.
4. ss raised after 5 bits of 8'hFF, then a full byte 8'h81 is sent -> only one done pulse, with dout=8'h81; the partial byte is discarded.
5. ready dropped mid-byte after 3 bits -> miso_en falls 1 cycle later, no done; after ready returns and ss is re-asserted, a fresh byte 8'h7E is received correctly.
6. rst asserted mid-byte -> all outputs 0 on the next cycle; the following full byte 8'hC3 is received correctly with a single done pulse.
